// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : button_bank
//  Description : N-channel pushbutton conditioner. Each channel synchronises,
//                debounces and classifies its key into press / click /
//                long-press / auto-repeat / release events.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_bank #(
    parameter int N            = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw,
    output logic [N-1:0] pressed,
    output logic [N-1:0] press,
    output logic [N-1:0] click,
    output logic [N-1:0] long_start,
    output logic [N-1:0] held,
    output logic [N-1:0] repeat_evt,
    output logic [N-1:0] release_evt,
    output logic [N-1:0] step
);

    localparam int c_DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEBOUNCE_CYC - 1);
    localparam logic [c_DW-1:0] c_DEB_ZERO  = '0;
    localparam logic [c_DW-1:0] c_DEB_ONE   = c_DW'(1);
    localparam logic [c_TW-1:0] c_HOLD_LAST = c_TW'(HOLD_CYC - 1);
    localparam logic [c_TW-1:0] c_REP_LAST  = c_TW'(REPEAT_CYC - 1);
    localparam logic [c_TW-1:0] c_T_ZERO    = '0;
    localparam logic [c_TW-1:0] c_T_ONE     = c_TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    if (DEBOUNCE_CYC < 1) begin : g_chk_deb
        $error("button_bank: DEBOUNCE_CYC must be >= 1");
    end
    if (HOLD_CYC < 2) begin : g_chk_hold
        $error("button_bank: HOLD_CYC must be >= 2");
    end
    if (REPEAT_CYC < 1) begin : g_chk_rep
        $error("button_bank: REPEAT_CYC must be >= 1");
    end

    // Normalise polarity so everything downstream treats 1 as "pressed".
    logic [N-1:0] w_p;
    assign w_p = ACTIVE_LOW ? ~raw : raw;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic            r_s1;
        logic            r_s2;
        logic            r_pressed;
        logic [c_DW-1:0] r_dcnt;
        logic            w_diff;
        logic            w_flip;
        logic            w_rise;
        logic            w_fall;

        state_t          r_state;
        logic [c_TW-1:0] r_tcnt;
        logic            r_press;
        logic            r_click;
        logic            r_long;
        logic            r_held;
        logic            r_rep;
        logic            r_rel;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_p[gi];
                r_s2 <= r_s1;
            end
        end

        // The toggle decision is shared combinationally with the event FSM so
        // that press/release events land on the same edge as the level change.
        assign w_diff = r_s2 ^ r_pressed;
        assign w_flip = w_diff && (r_dcnt == c_DEB_LAST);
        assign w_rise = w_flip && r_s2;
        assign w_fall = w_flip && !r_s2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pressed <= 1'b0;
                r_dcnt    <= c_DEB_ZERO;
            end else if (!w_diff) begin
                r_dcnt    <= c_DEB_ZERO;
            end else if (w_flip) begin
                r_pressed <= ~r_pressed;
                r_dcnt    <= c_DEB_ZERO;
            end else begin
                r_dcnt    <= r_dcnt + c_DEB_ONE;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_tcnt  <= c_T_ZERO;
                r_press <= 1'b0;
                r_click <= 1'b0;
                r_long  <= 1'b0;
                r_held  <= 1'b0;
                r_rep   <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_click <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
                r_rel   <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            r_press <= 1'b1;
                            r_tcnt  <= c_T_ZERO;
                            r_state <= S_PRESS;
                        end
                    end
                    S_PRESS: begin
                        // A release on the threshold cycle is still a click.
                        if (w_fall) begin
                            r_click <= 1'b1;
                            r_rel   <= 1'b1;
                            r_tcnt  <= c_T_ZERO;
                            r_state <= S_IDLE;
                        end else if (r_tcnt == c_HOLD_LAST) begin
                            r_long  <= 1'b1;
                            r_held  <= 1'b1;
                            r_tcnt  <= c_T_ZERO;
                            r_state <= S_HOLD;
                        end else begin
                            r_tcnt  <= r_tcnt + c_T_ONE;
                        end
                    end
                    S_HOLD: begin
                        if (w_fall) begin
                            r_rel   <= 1'b1;
                            r_held  <= 1'b0;
                            r_tcnt  <= c_T_ZERO;
                            r_state <= S_IDLE;
                        end else if (r_tcnt == c_REP_LAST) begin
                            r_rep   <= 1'b1;
                            r_tcnt  <= c_T_ZERO;
                        end else begin
                            r_tcnt  <= r_tcnt + c_T_ONE;
                        end
                    end
                    default: begin
                        r_held  <= 1'b0;
                        r_tcnt  <= c_T_ZERO;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign pressed[gi]     = r_pressed;
        assign press[gi]       = r_press;
        assign click[gi]       = r_click;
        assign long_start[gi]  = r_long;
        assign held[gi]        = r_held;
        assign repeat_evt[gi]  = r_rep;
        assign release_evt[gi] = r_rel;
        assign step[gi]        = r_press | r_rep;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_bank
//  Description : Directed self-checking bench for button_bank
//                (N=4, active-low, DEBOUNCE=4, HOLD=20, REPEAT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] click;
    logic [3:0] long_start;
    logic [3:0] held;
    logic [3:0] repeat_evt;
    logic [3:0] release_evt;
    logic [3:0] step;

    int n_vec;
    int n_err;

    button_bank #(
        .N            (4),
        .ACTIVE_LOW   (1'b1),
        .DEBOUNCE_CYC (4),
        .HOLD_CYC     (20),
        .REPEAT_CYC   (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (raw),
        .pressed     (pressed),
        .press       (press),
        .click       (click),
        .long_start  (long_start),
        .held        (held),
        .repeat_evt  (repeat_evt),
        .release_evt (release_evt),
        .step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return {pressed, press, click, long_start, held, repeat_evt, release_evt, step};
    endfunction

    function automatic logic [3:0] on(input bit c, input logic [3:0] m);
        return c ? m : 4'b0000;
    endfunction

    // Expected word; step is derived from the expected press/repeat bits.
    function automatic logic [31:0] pk(input logic [3:0] pr, input logic [3:0] ps,
                                       input logic [3:0] ck, input logic [3:0] ls,
                                       input logic [3:0] hd, input logic [3:0] rp,
                                       input logic [3:0] rl);
        return {pr, ps, ck, ls, hd, rp, rl, ps | rp};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        raw   = 4'hF;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset", obs(), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle", obs(), 32'h0);

        // Short press on channel 0: press at edge 6, release at edge 16.
        raw[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("short e%0d", e), obs(),
                  pk(on(e >= 6 && e < 16, 4'b0001), on(e == 6, 4'b0001),
                     on(e == 16, 4'b0001), 4'b0, 4'b0, 4'b0, on(e == 16, 4'b0001)));
            if (e == 10) raw[0] = 1'b1;
        end

        // Bounce on channel 1: 3-cycle runs never reach the 4-cycle debounce.
        for (int e = 1; e <= 40; e++) begin
            if (e <= 30) raw[1] = (((e - 1) / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else         raw[1] = 1'b1;
            tick();
            check($sformatf("bounce e%0d", e), obs(), 32'h0);
        end

        // Long press on channel 2: t=6, long at 26, repeats 34..66, release 72.
        raw[2] = 1'b0;
        for (int e = 1; e <= 75; e++) begin
            tick();
            check($sformatf("long e%0d", e), obs(),
                  pk(on(e >= 6 && e < 72, 4'b0100), on(e == 6, 4'b0100), 4'b0,
                     on(e == 26, 4'b0100), on(e >= 26 && e < 72, 4'b0100),
                     on(e == 34 || e == 42 || e == 50 || e == 58 || e == 66, 4'b0100),
                     on(e == 72, 4'b0100)));
            if (e == 66) raw[2] = 1'b1;
        end

        // Boundary on channel 0: debounced fall lands exactly at t+20.
        raw[0] = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            check($sformatf("bound e%0d", e), obs(),
                  pk(on(e >= 6 && e < 26, 4'b0001), on(e == 6, 4'b0001),
                     on(e == 26, 4'b0001), 4'b0, 4'b0, 4'b0, on(e == 26, 4'b0001)));
            if (e == 20) raw[0] = 1'b1;
        end

        // Reset while channel 3 is in HOLD.
        raw[3] = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            check($sformatf("hold3 e%0d", e), obs(),
                  pk(on(e >= 6, 4'b1000), on(e == 6, 4'b1000), 4'b0,
                     on(e == 26, 4'b1000), on(e >= 26, 4'b1000), 4'b0, 4'b0));
        end
        rst_n = 1'b0;
        #2;
        check("rst_async", obs(), 32'h0);
        tick();
        check("rst_hold1", obs(), 32'h0);
        tick();
        check("rst_hold2", obs(), 32'h0);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            check($sformatf("repress e%0d", e), obs(),
                  pk(on(e >= 6 && e < 14, 4'b1000), on(e == 6, 4'b1000),
                     on(e == 14, 4'b1000), 4'b0, 4'b0, 4'b0, on(e == 14, 4'b1000)));
            if (e == 8) raw[3] = 1'b1;
        end

        // All four keys pressed in the same cycle.
        raw = 4'h0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("all e%0d", e), obs(),
                  pk(on(e >= 6 && e < 16, 4'hF), on(e == 6, 4'hF),
                     on(e == 16, 4'hF), 4'b0, 4'b0, 4'b0, on(e == 16, 4'hF)));
            if (e == 10) raw = 4'hF;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_bank.md
# button_bank

Parametrised N-channel pushbutton conditioner that generalises the single-button click/hold logic used in the lab front panel. Each channel synchronises a raw switch input, debounces it, and classifies it into press, short-click, long-press, auto-repeat and release events. The `step` output gives a single increment/decrement pulse per channel: one on press, then one per auto-repeat while held. It sits between the board KEY pins and the display/offset control logic.

## Interface
- `N`, 4: number of button channels
- `ACTIVE_LOW`, 1: 1 = raw input low means pressed (DE1-SoC KEY); 0 = raw high means pressed
- `DEBOUNCE_CYC`, 500_000: consecutive stable cycles needed to change the debounced level (10 ms at 50 MHz); must be ≥ 1
- `HOLD_CYC`, 25_000_000: cycles from press to long-press (0.5 s); must be ≥ 2
- `REPEAT_CYC`, 10_000_000: auto-repeat period while long-pressed (5 Hz); must be ≥ 1


- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `raw`  in  N  unsynchronised button pins
- `pressed`  out  N  debounced level, 1 = pressed
- `press`  out  N  1-cycle pulse on debounced press
- `click`  out  N  1-cycle pulse on release before long-press threshold
- `long_start`  out  N  1-cycle pulse when press reaches HOLD_CYC
- `held`  out  N  level, 1 while channel is in long-press
- `repeat_evt`  out  N  1-cycle pulse every REPEAT_CYC while held
- `release_evt`  out  N  1-cycle pulse on any debounced release
- `step`  out  N  `press | repeat_evt`

## Operation
- Channels are fully independent and identical; there is no cross-channel priority.
- Polarity: the input is normalised to `p = ACTIVE_LOW ? ~raw : raw` before synchronisation.
- Sync: a 2-flop synchroniser per channel, reset to 0 (unpressed).
- Debounce, per channel:
  - Counter `dcnt` of width `$clog2(DEBOUNCE_CYC+1)`.
  - If the synced value equals `pressed`, `dcnt` clears to 0.
  - Otherwise `dcnt` increments.
  - When `dcnt == DEBOUNCE_CYC-1` and the value still differs, `pressed` toggles and `dcnt` clears.
- Event FSM, per channel, states IDLE, PRESS, HOLD, with timer `tcnt` of width `$clog2(max(HOLD_CYC,REPEAT_CYC)+1)`:
  - IDLE: on a debounced rise, pulse `press`, clear `tcnt`, go to PRESS.
  - PRESS: `tcnt` increments each cycle.
    - On a debounced fall: pulse `click` and `release_evt`, go to IDLE.
    - Otherwise, when `tcnt == HOLD_CYC-1`: pulse `long_start`, clear `tcnt`, go to HOLD.
  - HOLD: `held = 1`; `tcnt` increments each cycle.
    - When `tcnt == REPEAT_CYC-1`: pulse `repeat_evt` and clear `tcnt`.
    - On a debounced fall: pulse `release_evt` only (no click), go to IDLE.
- All event outputs are registered and high for exactly one cycle.
- `held` and `pressed` are registered levels.
- No counter saturates or wraps in normal operation, because every counter clears at its threshold.

## Timing
- Reset: every output is 0, the FSM is in IDLE, all counters are 0, and the sync flops are 0. Reset is asynchronous, with synchronous deassertion at the system level.
- Press latency: `p` rises and stays stable before edge k. Then `pressed` and `press` are high in the cycle after edge k+1+DEBOUNCE_CYC.
- Release latency is symmetric: `pressed` falls, and `release_evt`/`click` pulse, DEBOUNCE_CYC+2 edges after `p` falls.
- Let `press` pulse in cycle t:
  - `long_start` and the rise of `held` occur in cycle t+HOLD_CYC.
  - The first `repeat_evt` occurs at t+HOLD_CYC+REPEAT_CYC, then every REPEAT_CYC cycles after that.
- `held` falls in the same cycle that `release_evt` pulses.
- Release in the same cycle as the hold threshold: the release wins. `click` and `release_evt` pulse; `long_start` does not.
- Release in the same cycle as a repeat threshold: the release wins and no `repeat_evt` is issued.
- A glitch shorter than DEBOUNCE_CYC cycles causes no change and no event.
- Reset mid-press returns the channel to IDLE with no events. If the button is still down after reset, it is detected as a new press after DEBOUNCE_CYC+2 cycles.
- `step` is combinational from registered `press | repeat_evt`, so it has zero added latency.

## Test plan
All scenarios use N=4, ACTIVE_LOW=1, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8.

- Short press: drive `raw[0]` low for 10 cycles, then high.
  - Required: `press[0]` pulses 6 edges after the fall.
  - Required: `click[0]` and `release_evt[0]` pulse 6 edges after the rise.
  - Required: no `long_start`, and other channels stay silent.
- Bounce: toggle `raw[1]` low/high every 3 cycles for 30 cycles, then hold it high. Required: every output stays 0.
- Long press: hold `raw[2]` low for 60 cycles after `press` (cycle t).
  - Required: `long_start[2]` at t+20.
  - Required: `repeat_evt[2]` at t+28, t+36, t+44, t+52, t+60, with `step[2]` pulsing at t and at each repeat.
  - Required: on release, `release_evt[2]` pulses with no click.
- Boundary: release timed so that the debounced fall lands at t+20. Required: `click` pulses and `long_start` never fires.
- Reset mid-hold: assert `rst_n=0` while channel 3 is HOLD.
  - Required: all outputs clear immediately, asynchronously.
  - Required: after deassert with the key still down, `press[3]` pulses 6 cycles later.
- Simultaneous: press all 4 keys in the same cycle. Required: four identical `press` pulses in the same cycle.
